axis_header_extractor: RTL and testbench

- Receive-side counterpart of the header-insertion path: strips a per-packet header of 1..DATA_BYTE_WD bytes from the front of each AXI-Stream packet.
- The header goes out on its own stream, right-aligned. The remaining payload is realigned onto full beats, with a left-aligned tkeep on the last beat.
- Sits at the ingress of the packet pipeline, ahead of protocol parsing.
- Byte order is MSB-first: byte 0 of a beat is tdata[DATA_WD-1 -: 8]. Input tkeep is contiguous and left-aligned; it is all-ones except on tlast beats.

---
 rtl/axis_pkg.sv | 30 +++
 rtl/axis_header_extractor_if.sv | 14 +
 rtl/axis_out_reg.sv | 43 ++++
 rtl/axis_header_extractor.sv | 198 +++++++++++++++++++
 tb/tb_axis_header_extractor.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream header extractor.
package axis_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StBody,
    StTail,
    StPass,
    StPassRest
  } state_e;

  // Widest tkeep the popcount helper accepts.
  localparam int unsigned MaxKeepWd = 64;

  // Byte counts carry one spare bit so residual + keep count cannot overflow.
  function automatic int unsigned cnt_width(input int unsigned bytes);
    return $clog2(bytes + 1) + 1;
  endfunction

  function automatic int unsigned popcount(input logic [MaxKeepWd-1:0] keep);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxKeepWd; i++) begin
      if (keep[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_header_extractor_if.sv
// Generic AXI-Stream bundle used for every port of the header extractor.
interface axis_header_extractor_if #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned KEEP_WD = 4
);
  logic               tvalid;
  logic               tready;
  logic [DATA_WD-1:0] tdata;
  logic [KEEP_WD-1:0] tkeep;
  logic               tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Registered valid/ready output stage; accepts a new beat whenever empty or draining.
module axis_out_reg #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned KEEP_WD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DATA_WD-1:0] data,
  input  logic [KEEP_WD-1:0] keep,
  input  logic               last,
  output logic               free,
  axis_header_extractor_if.master m
);
  logic               valid_q;
  logic [DATA_WD-1:0] data_q;
  logic [KEEP_WD-1:0] keep_q;
  logic               last_q;

  assign free = !valid_q || m.tready;

  // Output register: reload only when the current beat is gone or leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (free) begin
      valid_q <= load;
      if (load) begin
        data_q <= data;
        keep_q <= keep;
        last_q <= last;
      end
    end
  end

  assign m.tvalid = valid_q;
  assign m.tdata  = data_q;
  assign m.tkeep  = keep_q;
  assign m.tlast  = last_q;
endmodule

// File: rtl/axis_header_extractor.sv
// Strips a 1..W byte header from each packet; header goes out right-aligned on m00,
// payload is realigned onto full beats on m01.
module axis_header_extractor
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic clk,
  input  logic rst,
  axis_header_extractor_if.slave  s00,
  axis_header_extractor_if.slave  s01,
  axis_header_extractor_if.master m00,
  axis_header_extractor_if.master m01,
  output logic short_pkt
);
  localparam int unsigned CW = cnt_width(DATA_BYTE_WD);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t W = cnt_t'(DATA_BYTE_WD);
  localparam logic [DATA_BYTE_WD-1:0] Ones = '1;
  localparam logic [DATA_WD-1:0] DataOnes = '1;

  state_e                  state_q, state_d;
  logic [LEN_WD-1:0]       len_q, len_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [DATA_WD-1:0]      tail_data_q, tail_data_d;
  logic [DATA_BYTE_WD-1:0] tail_keep_q, tail_keep_d;
  logic                    short_q, short_d;

  cnt_t l_cnt, r_cnt, k_cnt, rk_cnt, wk_cnt;
  logic [DATA_WD-1:0] body_data, res_mask;

  logic                    hdr_load, pay_load, pay_last, m00_free, m01_free;
  logic [DATA_WD-1:0]      hdr_data, pay_data;
  logic [DATA_BYTE_WD-1:0] hdr_keep, pay_keep;

  // The length stream carries no keep/last information.
  logic unused_s00;
  assign unused_s00 = ^{s00.tkeep, s00.tlast};

  assign l_cnt     = cnt_t'(len_q);
  assign r_cnt     = W - l_cnt;
  assign k_cnt     = cnt_t'(popcount(MaxKeepWd'(s01.tkeep)));
  assign rk_cnt    = r_cnt + k_cnt;
  assign wk_cnt    = W - k_cnt;
  assign res_mask  = DataOnes >> {l_cnt, 3'b000};
  assign body_data = DATA_WD'({res_q, s01.tdata} >> {r_cnt, 3'b000});

  // FSM state, latched header length and residual bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      res_q       <= '0;
      tail_data_q <= '0;
      tail_keep_q <= '0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      res_q       <= res_d;
      tail_data_q <= tail_data_d;
      tail_keep_q <= tail_keep_d;
      short_q     <= short_d;
    end
  end

  // Next state, input ready and output-stage load values.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    res_d       = res_q;
    tail_data_d = tail_data_q;
    tail_keep_d = tail_keep_q;
    short_d     = 1'b0;
    s00.tready  = 1'b0;
    s01.tready  = 1'b0;
    hdr_load    = 1'b0;
    hdr_data    = '0;
    hdr_keep    = '0;
    pay_load    = 1'b0;
    pay_data    = '0;
    pay_keep    = '0;
    pay_last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        s00.tready = !rst;
        if (s00.tvalid && s00.tready) begin
          len_d = s00.tdata;
          if (s00.tdata == '0 || cnt_t'(s00.tdata) > W) state_d = StPass;
          else                                          state_d = StHdr;
        end
      end
      StPass, StPassRest: begin
        s01.tready = !rst && m01_free;
        if (s01.tvalid && s01.tready) begin
          pay_load = 1'b1;
          pay_data = s01.tdata;
          pay_keep = s01.tkeep;
          pay_last = s01.tlast;
          if (s01.tlast) state_d = StIdle;
        end
      end
      StHdr: begin
        s01.tready = !rst && m00_free && m01_free;
        if (s01.tvalid && s01.tready) begin
          hdr_load = 1'b1;
          if (s01.tlast && k_cnt <= l_cnt) begin
            // Whole packet fits in the header: emit what arrived, no payload.
            hdr_data = s01.tdata >> {wk_cnt, 3'b000};
            hdr_keep = Ones >> wk_cnt;
            short_d  = 1'b1;
            state_d  = StIdle;
          end else begin
            hdr_data = s01.tdata >> {r_cnt, 3'b000};
            hdr_keep = Ones >> r_cnt;
            if (l_cnt == W) begin
              state_d = StPassRest;
            end else begin
              res_d = s01.tdata & res_mask;
              if (s01.tlast) begin
                pay_load = 1'b1;
                pay_data = s01.tdata << {l_cnt, 3'b000};
                pay_keep = s01.tkeep << l_cnt;
                pay_last = 1'b1;
                state_d  = StIdle;
              end else begin
                state_d = StBody;
              end
            end
          end
        end
      end
      StBody: begin
        s01.tready = !rst && m01_free;
        if (s01.tvalid && s01.tready) begin
          pay_load = 1'b1;
          pay_data = body_data;
          pay_keep = Ones;
          res_d    = s01.tdata & res_mask;
          if (s01.tlast) begin
            if (rk_cnt <= W) begin
              pay_keep = Ones << (W - rk_cnt);
              pay_last = 1'b1;
              state_d  = StIdle;
            end else begin
              // Leftover bytes of this beat need one more output beat.
              tail_data_d = s01.tdata;
              tail_keep_d = s01.tkeep;
              state_d     = StTail;
            end
          end
        end
      end
      StTail: begin
        if (m01_free) begin
          pay_load = 1'b1;
          pay_data = tail_data_q << {l_cnt, 3'b000};
          pay_keep = tail_keep_q << l_cnt;
          pay_last = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign short_pkt = short_q;

  axis_out_reg #(
    .DATA_WD (DATA_WD),
    .KEEP_WD (DATA_BYTE_WD)
  ) u_hdr_reg (
    .clk  (clk),
    .rst  (rst),
    .load (hdr_load),
    .data (hdr_data),
    .keep (hdr_keep),
    .last (1'b1),
    .free (m00_free),
    .m    (m00)
  );

  axis_out_reg #(
    .DATA_WD (DATA_WD),
    .KEEP_WD (DATA_BYTE_WD)
  ) u_pay_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pay_load),
    .data (pay_data),
    .keep (pay_keep),
    .last (pay_last),
    .free (m01_free),
    .m    (m01)
  );
endmodule

// File: tb/tb_axis_header_extractor.sv
// Directed bench for axis_header_extractor with W=4 bytes per beat.
module tb_axis_header_extractor;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int unsigned LW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic short_pkt;
  logic throttle = 1'b0;

  int errors = 0;
  int checks = 0;
  int short_cnt = 0;
  int short_base = 0;

  logic [36:0] q00[$];
  logic [36:0] q01[$];
  logic [36:0] e00[$];
  logic [36:0] e01[$];

  always #5 clk = ~clk;

  axis_header_extractor_if #(.DATA_WD(LW), .KEEP_WD(1))  s00_if ();
  axis_header_extractor_if #(.DATA_WD(DW), .KEEP_WD(KW)) s01_if ();
  axis_header_extractor_if #(.DATA_WD(DW), .KEEP_WD(KW)) m00_if ();
  axis_header_extractor_if #(.DATA_WD(DW), .KEEP_WD(KW)) m01_if ();

  axis_header_extractor #(.DATA_WD(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s00       (s00_if),
    .s01       (s01_if),
    .m00       (m00_if),
    .m01       (m01_if),
    .short_pkt (short_pkt)
  );

  // Byte j of keep qualifies tdata[8j+7:8j]; unqualified lanes compare as zero.
  function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) if (k[j]) m[8*j +: 8] = d[8*j +: 8];
    return m;
  endfunction

  // Output ready drivers: random when throttling, otherwise always ready.
  initial begin
    m00_if.tready = 1'b1;
    m01_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (throttle) begin
        m00_if.tready = 1'($urandom_range(0, 1));
        m01_if.tready = 1'($urandom_range(0, 1));
      end else begin
        m00_if.tready = 1'b1;
        m01_if.tready = 1'b1;
      end
    end
  end

  // Capture every output handshake, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m00_if.tvalid && m00_if.tready)
        q00.push_back({mask(m00_if.tdata, m00_if.tkeep), m00_if.tkeep, 1'b0});
      if (m01_if.tvalid && m01_if.tready)
        q01.push_back({mask(m01_if.tdata, m01_if.tkeep), m01_if.tkeep, m01_if.tlast});
      if (short_pkt) short_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_len(input logic [2:0] l);
    bit hs;
    int n;
    s00_if.tdata  = l;
    s00_if.tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = s00_if.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 200);
    s00_if.tvalid = 1'b0;
    check("s00_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit hs;
    int n;
    s01_if.tdata  = d;
    s01_if.tkeep  = k;
    s01_if.tlast  = l;
    s01_if.tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      hs = s01_if.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 200);
    s01_if.tvalid = 1'b0;
    check("s01_handshake", 64'(hs), 64'd1);
  endtask

  task automatic exp00(input logic [31:0] d, input logic [3:0] k);
    e00.push_back({d, k, 1'b0});
  endtask

  task automatic exp01(input logic [31:0] d, input logic [3:0] k, input logic l);
    e01.push_back({d, k, l});
  endtask

  task automatic drain(input int n);
    throttle = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag, input int exp_short);
    check({tag, "_m00_count"}, 64'(q00.size()), 64'(e00.size()));
    for (int i = 0; i < e00.size(); i++)
      if (i < q00.size()) check($sformatf("%s_m00[%0d]", tag, i), 64'(q00[i]), 64'(e00[i]));
    check({tag, "_m01_count"}, 64'(q01.size()), 64'(e01.size()));
    for (int i = 0; i < e01.size(); i++)
      if (i < q01.size()) check($sformatf("%s_m01[%0d]", tag, i), 64'(q01[i]), 64'(e01[i]));
    check({tag, "_short"}, 64'(short_cnt - short_base), 64'(exp_short));
    q00.delete();
    q01.delete();
    e00.delete();
    e01.delete();
    short_base = short_cnt;
  endtask

  // L=2 on bytes 00..09.
  task automatic run_l2(input string tag);
    send_len(3'd2);
    send_beat(32'h00010203, 4'hf, 1'b0);
    send_beat(32'h04050607, 4'hf, 1'b0);
    send_beat(32'h0809aaaa, 4'hc, 1'b1);
    exp00(32'h00000001, 4'h3);
    exp01(32'h02030405, 4'hf, 1'b0);
    exp01(32'h06070809, 4'hf, 1'b1);
    drain(8);
    compare_all(tag, 0);
  endtask

  initial begin
    s00_if.tvalid = 1'b0;
    s00_if.tdata  = '0;
    s00_if.tkeep  = '0;
    s00_if.tlast  = 1'b0;
    s01_if.tvalid = 1'b0;
    s01_if.tdata  = '0;
    s01_if.tkeep  = '0;
    s01_if.tlast  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m00_valid", 64'(m00_if.tvalid), 64'd0);
    check("rst_m01_valid", 64'(m01_if.tvalid), 64'd0);
    check("rst_m01_data", 64'(m01_if.tdata), 64'd0);
    check("rst_m01_keep_last", 64'({m01_if.tkeep, m01_if.tlast}), 64'd0);
    check("rst_m00_data", 64'(m00_if.tdata), 64'd0);
    check("rst_short", 64'(short_pkt), 64'd0);
    check("rst_s00_ready", 64'(s00_if.tready), 64'd0);
    check("rst_s01_ready", 64'(s01_if.tready), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_s00_ready", 64'(s00_if.tready), 64'd1);
    check("idle_s01_ready", 64'(s01_if.tready), 64'd0);

    // 1: L=2, last beat fits after the residual
    run_l2("t1");

    // 2: L=3
    send_len(3'd3);
    send_beat(32'h00010203, 4'hf, 1'b0);
    send_beat(32'h04050607, 4'hf, 1'b0);
    send_beat(32'h0809aaaa, 4'hc, 1'b1);
    exp00(32'h00000102, 4'h7);
    exp01(32'h03040506, 4'hf, 1'b0);
    exp01(32'h07080900, 4'he, 1'b1);
    drain(8);
    compare_all("t2", 0);

    // 3: L=1, residual plus last beat overflows into a tail beat
    send_len(3'd1);
    send_beat(32'h00010203, 4'hf, 1'b0);
    send_beat(32'h04050607, 4'hf, 1'b0);
    send_beat(32'h0809aaaa, 4'hc, 1'b1);
    exp00(32'h00000000, 4'h1);
    exp01(32'h01020304, 4'hf, 1'b0);
    exp01(32'h05060708, 4'hf, 1'b0);
    exp01(32'h09000000, 4'h8, 1'b1);
    drain(8);
    compare_all("t3", 0);

    // 4a: L=W, header is the whole first beat
    send_len(3'd4);
    send_beat(32'h00010203, 4'hf, 1'b0);
    send_beat(32'h04050607, 4'hf, 1'b1);
    exp00(32'h00010203, 4'hf);
    exp01(32'h04050607, 4'hf, 1'b1);
    drain(8);
    compare_all("t4a", 0);

    // 4b: L=0 bypass
    send_len(3'd0);
    send_beat(32'h00010203, 4'hf, 1'b0);
    send_beat(32'h04050607, 4'hf, 1'b1);
    exp01(32'h00010203, 4'hf, 1'b0);
    exp01(32'h04050607, 4'hf, 1'b1);
    drain(8);
    compare_all("t4b", 0);

    // 4c: L>W also bypasses
    send_len(3'd5);
    send_beat(32'h40414243, 4'hf, 1'b0);
    send_beat(32'h4445aaaa, 4'hc, 1'b1);
    exp01(32'h40414243, 4'hf, 1'b0);
    exp01(32'h44450000, 4'hc, 1'b1);
    drain(8);
    compare_all("t4c", 0);

    // 5: short packet, then a normal one
    send_len(3'd3);
    send_beat(32'h0001aaaa, 4'hc, 1'b1);
    exp00(32'h00000001, 4'h3);
    drain(8);
    compare_all("t5", 1);
    run_l2("t5_next");

    // 6a: throttled outputs, L=2, 22 bytes 10..25
    throttle = 1'b1;
    send_len(3'd2);
    send_beat(32'h10111213, 4'hf, 1'b0);
    send_beat(32'h14151617, 4'hf, 1'b0);
    send_beat(32'h18191a1b, 4'hf, 1'b0);
    send_beat(32'h1c1d1e1f, 4'hf, 1'b0);
    send_beat(32'h20212223, 4'hf, 1'b0);
    send_beat(32'h2425aaaa, 4'hc, 1'b1);
    exp00(32'h00001011, 4'h3);
    exp01(32'h12131415, 4'hf, 1'b0);
    exp01(32'h16171819, 4'hf, 1'b0);
    exp01(32'h1a1b1c1d, 4'hf, 1'b0);
    exp01(32'h1e1f2021, 4'hf, 1'b0);
    exp01(32'h22232425, 4'hf, 1'b1);
    drain(12);
    compare_all("t6_throttle", 0);

    // 6b: reset in the middle of the body
    throttle = 1'b1;
    send_len(3'd1);
    send_beat(32'h30313233, 4'hf, 1'b0);
    send_beat(32'h34353637, 4'hf, 1'b0);
    exp00(32'h00000030, 4'h1);
    exp01(32'h31323334, 4'hf, 1'b0);
    drain(6);
    compare_all("t6_pre_reset", 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_rst_m00_valid", 64'(m00_if.tvalid), 64'd0);
    check("t6_rst_m01_valid", 64'(m01_if.tvalid), 64'd0);
    check("t6_rst_s01_ready", 64'(s01_if.tready), 64'd0);
    rst = 1'b0;
    #1;
    check("t6_idle_s00_ready", 64'(s00_if.tready), 64'd1);
    check("t6_idle_s01_ready", 64'(s01_if.tready), 64'd0);
    run_l2("t6_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
